tia_beam_scheduler: RTL

- Sequences the TIA beam: owns the horizontal/vertical beam counters and paces one beam step per LCD pixel slot against the ili9341 busy handshake.
- Issues pixel-write strobes with coordinates to the TIA pixel pipeline.
- Owns the CPU stall that WSYNC requests and releases at horizontal blank, and handles VSYNC resynchronisation with the LCD cursor reset.
- Sits between the wishbone TIA register file, which supplies the request pulses, and the LCD driver.

---
 rtl/tia_beam_scheduler_if.sv | 29 ++
 rtl/tia_beam_scheduler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/tia_beam_scheduler_if.sv
// Request, LCD handshake, beam position and pixel-strobe signals exchanged
// between the beam scheduler and its neighbours.
interface tia_beam_scheduler_if;
    logic        vsync_req_i;
    logic        wsync_req_i;
    logic        lcd_busy_i;
    logic [10:0] xpos_o;
    logic [9:0]  ypos_o;
    logic        pix_valid_o;
    logic [10:0] pix_x_o;
    logic [9:0]  pix_y_o;
    logic        pix_active_o;
    logic        cursor_reset_o;
    logic        stall_cpu_o;
    logic        hblank_o;
    logic        frame_done_o;

    modport slave (
        input  vsync_req_i, wsync_req_i, lcd_busy_i,
        output xpos_o, ypos_o, pix_valid_o, pix_x_o, pix_y_o, pix_active_o,
               cursor_reset_o, stall_cpu_o, hblank_o, frame_done_o
    );

    modport master (
        output vsync_req_i, wsync_req_i, lcd_busy_i,
        input  xpos_o, ypos_o, pix_valid_o, pix_x_o, pix_y_o, pix_active_o,
               cursor_reset_o, stall_cpu_o, hblank_o, frame_done_o
    );
endinterface

// File: rtl/tia_beam_scheduler.sv
// TIA beam sequencer: steps the beam counters once per LCD pixel slot, strobes
// pixels, and owns the WSYNC CPU stall and VSYNC resynchronisation.
module tia_beam_scheduler #(
    parameter int unsigned H_TOTAL     = 456,
    parameter int unsigned H_VISIBLE   = 320,
    parameter int unsigned V_TOTAL     = 262,
    parameter int unsigned V_VISIBLE   = 240,
    parameter int unsigned V_TOP       = 24,
    parameter int unsigned V_BOT       = 226,
    parameter int unsigned PACE_CYCLES = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    tia_beam_scheduler_if.slave     bus
);
    localparam int unsigned PW = (PACE_CYCLES > 2) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [PW-1:0] PACE_LOAD = PW'(PACE_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PACE   = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pace;
    logic [10:0]   r_xpos;
    logic [9:0]    r_ypos;
    logic          r_pix_valid;
    logic [10:0]   r_pix_x;
    logic [9:0]    r_pix_y;
    logic          r_pix_active;
    logic          r_cursor_reset;
    logic          r_stall;
    logic          r_frame_done;

    logic w_step;
    logic w_visible;
    logic w_picture;
    logic w_x_last;
    logic w_y_last;
    logic w_hblank_edge;

    assign w_step        = (r_state == ST_RUN) && !bus.lcd_busy_i;
    assign w_visible     = (r_ypos < 10'(V_VISIBLE)) && (r_xpos < 11'(H_VISIBLE));
    assign w_picture     = (r_ypos >= 10'(V_TOP)) && (r_ypos < 10'(V_BOT));
    assign w_x_last      = (r_xpos == 11'(H_TOTAL - 1));
    assign w_y_last      = (r_ypos == 10'(V_TOTAL - 1));
    assign w_hblank_edge = (r_xpos == 11'(H_VISIBLE - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_RUN;
            r_pace         <= '0;
            r_xpos         <= '0;
            r_ypos         <= '0;
            r_pix_valid    <= 1'b0;
            r_pix_x        <= '0;
            r_pix_y        <= '0;
            r_pix_active   <= 1'b0;
            r_cursor_reset <= 1'b0;
            r_stall        <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_pix_valid    <= 1'b0;
            r_cursor_reset <= 1'b0;
            r_frame_done   <= 1'b0;
            if (bus.vsync_req_i) begin
                // VSYNC outranks busy, pacing and any WSYNC in the same cycle
                r_xpos         <= '0;
                r_ypos         <= '0;
                r_cursor_reset <= 1'b1;
                r_stall        <= 1'b0;
                r_state        <= ST_RESYNC;
            end else begin
                if (bus.wsync_req_i) begin
                    r_stall <= 1'b1;
                end else if (w_step && w_hblank_edge) begin
                    r_stall <= 1'b0;
                end
                case (r_state)
                    ST_RUN: begin
                        if (!bus.lcd_busy_i) begin
                            if (w_visible) begin
                                r_pix_valid  <= 1'b1;
                                r_pix_x      <= r_xpos;
                                r_pix_y      <= r_ypos;
                                r_pix_active <= w_picture;
                            end else begin
                                r_pix_active <= 1'b0;
                            end
                            if (!w_x_last) begin
                                r_xpos <= r_xpos + 11'd1;
                            end else begin
                                r_xpos <= '0;
                                if (!w_y_last) begin
                                    r_ypos <= r_ypos + 10'd1;
                                end else begin
                                    r_ypos       <= '0;
                                    r_frame_done <= 1'b1;
                                end
                            end
                            r_pace  <= PACE_LOAD;
                            r_state <= ST_PACE;
                        end
                    end
                    ST_PACE: begin
                        // Counter is loaded with PACE_CYCLES-2 so PACE lasts PACE_CYCLES-1 cycles
                        if (r_pace == '0) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_pace <= r_pace - PW'(1);
                        end
                    end
                    ST_RESYNC: begin
                        r_pace  <= PACE_LOAD;
                        r_state <= ST_PACE;
                    end
                    default: r_state <= ST_RUN;
                endcase
            end
        end
    end

    assign bus.xpos_o         = r_xpos;
    assign bus.ypos_o         = r_ypos;
    assign bus.pix_valid_o    = r_pix_valid;
    assign bus.pix_x_o        = r_pix_x;
    assign bus.pix_y_o        = r_pix_y;
    assign bus.pix_active_o   = r_pix_active;
    assign bus.cursor_reset_o = r_cursor_reset;
    assign bus.stall_cpu_o    = r_stall;
    assign bus.frame_done_o   = r_frame_done;
    assign bus.hblank_o       = (r_xpos >= 11'(H_VISIBLE));
endmodule
